// File: rtl/gowin_rx_skid.sv
// Receive skid FIFO between the Gowin PCIe core TL RX port and the consumer.
// Ports: tl_rx_* from core, tl_rx_wait back to core, rx_* head out, rx_ready in,
// rx_ovf sticky drop flag, stat_* counters (GOWIN_RX_SKID_STATS_EN, else 0).
module gowin_rx_skid #(
  parameter int C_PCI_DATA_WIDTH = 256,
  parameter int C_DEPTH          = 8,
  parameter int C_WAIT_LATENCY   = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        tl_rx_sop,
  input  logic                        tl_rx_eop,
  input  logic [C_PCI_DATA_WIDTH-1:0] tl_rx_data,
  input  logic [7:0]                  tl_rx_valid,
  input  logic [5:0]                  tl_rx_bardec,
  output logic                        tl_rx_wait,
  output logic                        rx_sop,
  output logic                        rx_eop,
  output logic [C_PCI_DATA_WIDTH-1:0] rx_data,
  output logic [7:0]                  rx_valid,
  output logic [5:0]                  rx_bardec,
  output logic                        rx_out_valid,
  input  logic                        rx_ready,
  output logic                        rx_ovf,
  output logic [15:0]                 stat_tlp_cnt,
  output logic [15:0]                 stat_wait_cnt
);

  localparam int AW = $clog2(C_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(C_DEPTH);
  localparam logic [AW:0] THR =
    (AW+1)'(C_DEPTH - C_WAIT_LATENCY - 1);

  typedef struct packed {
    logic                        sop;
    logic                        eop;
    logic [7:0]                  valid;
    logic [5:0]                  bardec;
    logic [C_PCI_DATA_WIDTH-1:0] data;
  } ent_t;

  ent_t mem [C_DEPTH];
  ent_t head;
  ent_t wr_ent;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_next;
  logic          beat_in;
  logic          full;
  logic          push;
  logic          pop;
  logic          drop;

  assign beat_in = |tl_rx_valid;
  assign full    = (count == FULL);
  assign pop     = rx_out_valid & rx_ready;
  // A pop frees the slot the incoming beat needs, even when full.
  assign push    = beat_in & (~full | pop);
  assign drop    = beat_in & full & ~pop;

  assign wr_ent.sop    = tl_rx_sop;
  assign wr_ent.eop    = tl_rx_eop;
  assign wr_ent.valid  = tl_rx_valid;
  assign wr_ent.bardec = tl_rx_bardec;
  assign wr_ent.data   = tl_rx_data;

  assign head         = mem[rd_ptr];
  assign rx_out_valid = (count != '0);
  assign rx_sop       = rx_out_valid & head.sop;
  assign rx_eop       = rx_out_valid & head.eop;
  assign rx_valid     = rx_out_valid ? head.valid : 8'h00;
  assign rx_bardec    = head.bardec;
  assign rx_data      = head.data;

  always_comb begin
    count_next = count;
    unique case (1'b1)
      push & ~pop: count_next = count + 1'b1;
      pop & ~push: count_next = count - 1'b1;
      default:     count_next = count;
    endcase
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_ent;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      tl_rx_wait <= 1'b0;
      rx_ovf     <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count      <= count_next;
      // Leaves room for the beats the core may still send.
      tl_rx_wait <= (count_next >= THR);
      if (drop) rx_ovf <= 1'b1;
    end
  end

`ifdef GOWIN_RX_SKID_STATS_EN
  logic [15:0] tlp_q;
  logic [15:0] wait_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tlp_q  <= '0;
      wait_q <= '0;
    end else begin
      if (push && tl_rx_sop && tlp_q != 16'hFFFF)
        tlp_q <= tlp_q + 16'd1;
      if (tl_rx_wait && wait_q != 16'hFFFF)
        wait_q <= wait_q + 16'd1;
    end
  end

  assign stat_tlp_cnt  = tlp_q;
  assign stat_wait_cnt = wait_q;
`else
  assign stat_tlp_cnt  = 16'h0000;
  assign stat_wait_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_gowin_rx_skid.sv
// Scoreboard bench for gowin_rx_skid.
// Model tracks count/wait/ovf and the expected FIFO contents.
module tb_gowin_rx_skid;

  localparam int EW = 272;

  logic         clk;
  logic         rst_n;
  logic         tl_rx_sop;
  logic         tl_rx_eop;
  logic [255:0] tl_rx_data;
  logic [7:0]   tl_rx_valid;
  logic [5:0]   tl_rx_bardec;
  logic         tl_rx_wait;
  logic         rx_sop;
  logic         rx_eop;
  logic [255:0] rx_data;
  logic [7:0]   rx_valid;
  logic [5:0]   rx_bardec;
  logic         rx_out_valid;
  logic         rx_ready;
  logic         rx_ovf;
  logic [15:0]  stat_tlp_cnt;
  logic [15:0]  stat_wait_cnt;

  gowin_rx_skid dut (
    .clk(clk), .rst_n(rst_n),
    .tl_rx_sop(tl_rx_sop), .tl_rx_eop(tl_rx_eop),
    .tl_rx_data(tl_rx_data), .tl_rx_valid(tl_rx_valid),
    .tl_rx_bardec(tl_rx_bardec), .tl_rx_wait(tl_rx_wait),
    .rx_sop(rx_sop), .rx_eop(rx_eop), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_bardec(rx_bardec),
    .rx_out_valid(rx_out_valid), .rx_ready(rx_ready),
    .rx_ovf(rx_ovf), .stat_tlp_cnt(stat_tlp_cnt),
    .stat_wait_cnt(stat_wait_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag,
                     input logic [EW-1:0] got,
                     input logic [EW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [EW-1:0] q[$];
  int            mcnt = 0;
  bit            movf = 0;
  bit            mwait = 0;
  int            mwcnt = 0;
  int            mtlp = 0;

  always @(negedge clk) begin
    bit in_v, pu, po;
    if (!rst_n) begin
      q.delete();
      mcnt  = 0;
      movf  = 0;
      mwait = 0;
      mwcnt = 0;
      mtlp  = 0;
    end else begin
      chk("out_valid", EW'(rx_out_valid), EW'(mcnt != 0));
      chk("wait", EW'(tl_rx_wait), EW'(mwait));
      chk("ovf", EW'(rx_ovf), EW'(movf));
      if (mcnt != 0)
        chk("head", {rx_sop, rx_eop, rx_valid, rx_bardec, rx_data}, q[0]);
      else
        chk("empty_valid", EW'(rx_valid), '0);
      in_v = |tl_rx_valid;
      po = (mcnt != 0) && rx_ready;
      pu = in_v && (mcnt < 8 || po);
      if (in_v && mcnt == 8 && !po) movf = 1;
      if (po) void'(q.pop_front());
      if (pu) q.push_back({tl_rx_sop, tl_rx_eop, tl_rx_valid,
                           tl_rx_bardec, tl_rx_data});
      if (pu && tl_rx_sop) mtlp++;
      mcnt = mcnt + int'(pu) - int'(po);
      if (mwait && mwcnt < 16'hFFFF) mwcnt++;
      mwait = (mcnt >= 5);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    tl_rx_sop   = 1'b0;
    tl_rx_eop   = 1'b0;
    tl_rx_valid = 8'h00;
  endtask

  task automatic send(input logic s, input logic e,
                      input logic [255:0] d,
                      input logic [5:0] b,
                      input logic [7:0] v);
    tl_rx_sop    = s;
    tl_rx_eop    = e;
    tl_rx_data   = d;
    tl_rx_bardec = b;
    tl_rx_valid  = v;
    cyc();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    cyc();
    chk("rst_out_valid", EW'(rx_out_valid), '0);
    chk("rst_valid", EW'(rx_valid), '0);
    chk("rst_sop", EW'(rx_sop), '0);
    chk("rst_eop", EW'(rx_eop), '0);
    chk("rst_wait", EW'(tl_rx_wait), '0);
    chk("rst_ovf", EW'(rx_ovf), '0);
    chk("rst_stat_tlp", EW'(stat_tlp_cnt), '0);
    chk("rst_stat_wait", EW'(stat_wait_cnt), '0);
    rst_n = 1'b1;
  endtask

  task automatic drain();
    idle();
    rx_ready = 1'b1;
    for (int k = 0; k < 30 && rx_out_valid; k++) cyc();
    cyc();
    chk("drain_done", EW'(rx_out_valid), '0);
    chk("drain_q", EW'(q.size()), '0);
  endtask

  int            sent;
  int            exp_tlp;
  logic [255:0]  pat;

  initial begin
    rst_n        = 1'b0;
    rx_ready     = 1'b0;
    tl_rx_data   = '0;
    tl_rx_bardec = '0;
    idle();
    do_reset();

    // pass-through
    rx_ready = 1'b1;
    pat = {32{8'hA5}};
    send(1'b1, 1'b1, pat, 6'h01, 8'hFF);
    idle();
    chk("pt_valid", EW'(rx_out_valid), EW'(1));
    chk("pt_fields", {rx_sop, rx_eop, rx_valid, rx_bardec, rx_data},
        {1'b1, 1'b1, 8'hFF, 6'h01, pat});
    cyc();
    chk("pt_one_cycle", EW'(rx_out_valid), '0);

    // wait threshold then fill to 8
    rx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send(i == 0, 1'b0, 256'(i + 16), 6'h02, 8'h0F);
      if (i == 3) chk("wait_below", EW'(tl_rx_wait), '0);
    end
    chk("wait_at5", EW'(tl_rx_wait), EW'(1));
    send(1'b0, 1'b0, 256'd21, 6'h02, 8'h0F);
    send(1'b0, 1'b1, 256'd22, 6'h02, 8'h0F);
    idle();
    cyc();
    chk("wait_at7", EW'(tl_rx_wait), EW'(1));
    chk("no_ovf_7", EW'(rx_ovf), '0);
    send(1'b1, 1'b1, 256'd23, 6'h03, 8'hFF);
    idle();

    // full plus pop
    rx_ready = 1'b1;
    send(1'b1, 1'b1, 256'd24, 6'h04, 8'h01);
    idle();
    rx_ready = 1'b0;
    cyc();
    chk("fpp_ovf", EW'(rx_ovf), '0);
    chk("fpp_head", EW'(rx_data), EW'(17));

    // overflow
    send(1'b1, 1'b1, 256'hDEAD, 6'h05, 8'hFF);
    idle();
    chk("ovf_set", EW'(rx_ovf), EW'(1));
    cyc();
`ifdef GOWIN_RX_SKID_STATS_EN
    chk("stat_wait", EW'(stat_wait_cnt), EW'(mwcnt));
`else
    chk("stat_wait", EW'(stat_wait_cnt), '0);
`endif
    drain();
    chk("ovf_sticky", EW'(rx_ovf), EW'(1));
    do_reset();
    chk("ovf_cleared", EW'(rx_ovf), '0);

    // pointer wrap with toggling ready
    sent = 0;
    for (int c = 0; c < 200 && sent < 20; c++) begin
      rx_ready = c[0];
      if (!tl_rx_wait) begin
        tl_rx_sop    = 1'b1;
        tl_rx_eop    = 1'b1;
        tl_rx_data   = 256'(sent + 32'h100);
        tl_rx_bardec = 6'(sent);
        tl_rx_valid  = 8'h3C;
        sent++;
      end else begin
        idle();
      end
      cyc();
    end
    chk("wrap_sent", EW'(sent), EW'(20));
    drain();
    chk("wrap_no_ovf", EW'(rx_ovf), '0);

    // stats
    do_reset();
    rx_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      send(1'b1, 1'b0, 256'(t), 6'h01, 8'hFF);
      send(1'b0, 1'b1, 256'(t + 8), 6'h01, 8'h0F);
    end
    idle();
    cyc();
    cyc();
`ifdef GOWIN_RX_SKID_STATS_EN
    exp_tlp = 3;
`else
    exp_tlp = 0;
`endif
    chk("stat_tlp", EW'(stat_tlp_cnt), EW'(exp_tlp));

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/gowin_rx_skid.md
GOWIN_RX_SKID -- requirements
Module: gowin_rx_skid

Interface
REQ-001 The module SHALL have parameter C_PCI_DATA_WIDTH, default 256, giving the data width in bits; the only supported value is 256.
REQ-002 The module SHALL have parameter C_DEPTH, default 8, giving the number of FIFO entries; it SHALL be a power of 2 and >= C_WAIT_LATENCY+2.
REQ-003 The module SHALL have parameter C_WAIT_LATENCY, default 2, giving the maximum number of beats the PCIe core may still present after it samples tl_rx_wait high.
REQ-004 The module SHALL have the following ports:
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- tl_rx_sop  in  1  start of TLP, from the core
- tl_rx_eop  in  1  end of TLP, from the core
- tl_rx_data  in  256  beat data, from the core
- tl_rx_valid  in  8  per-dword valid, from the core; a beat is present when non-zero
- tl_rx_bardec  in  6  BAR hit, from the core
- tl_rx_wait  out  1  backpressure to the core, registered
- rx_sop  out  1  FIFO head sop
- rx_eop  out  1  FIFO head eop
- rx_data  out  256  FIFO head data
- rx_valid  out  8  FIFO head dword valid; 0 when empty
- rx_bardec  out  6  FIFO head bardec
- rx_out_valid  out  1  FIFO non-empty
- rx_ready  in  1  consumer accepts the head this cycle
- rx_ovf  out  1  sticky overflow flag
- stat_tlp_cnt  out  16  TLPs received (see Configuration)
- stat_wait_cnt  out  16  cycles with tl_rx_wait high (see Configuration)

Function
REQ-005 Push SHALL occur when tl_rx_valid != 0 and (count < C_DEPTH or a pop occurs in the same cycle); the entry stores {sop, eop, valid, bardec, data}.
REQ-006 Pop SHALL occur when rx_out_valid && rx_ready; rx_ready while empty SHALL have no effect.
REQ-007 Latency SHALL be 1 cycle: a beat pushed at edge N is visible on the rx_* outputs after edge N when the FIFO was empty before the push.
REQ-008 rx_* head outputs SHALL hold stable while rx_out_valid=1 and rx_ready=0.
REQ-009 Simultaneous push and pop SHALL leave count unchanged, including when count = C_DEPTH and when count = 1.
REQ-010 Read and write pointers SHALL be log2(C_DEPTH) bits and wrap modulo C_DEPTH; count SHALL be log2(C_DEPTH)+1 bits.
REQ-011 The tl_rx_wait register SHALL be loaded each cycle with (count_next >= C_DEPTH - C_WAIT_LATENCY - 1), where count_next is the post-edge count.
REQ-012 A beat presented when count = C_DEPTH with no pop SHALL be dropped, the FIFO left unchanged, and rx_ovf set to 1 until reset.
REQ-013 The block SHALL NOT check or alter TLP framing; sop/eop SHALL pass through unmodified.

Reset
REQ-014 On rst_n low, asynchronously: pointers=0, count=0, tl_rx_wait=0, rx_ovf=0, stat counters=0, rx_out_valid=0, rx_valid=0.
REQ-015 On rst_n low, rx_sop and rx_eop SHALL read 0; FIFO storage SHALL NOT be reset.
REQ-016 Reset asserted mid-TLP SHALL discard all stored beats; after release the first accepted beat is treated normally regardless of sop.

Configuration
REQ-017 With macro GOWIN_RX_SKID_STATS_EN defined, stat_tlp_cnt SHALL increment on each pushed beat with sop=1, and stat_wait_cnt SHALL increment each cycle tl_rx_wait=1; both SHALL saturate at 16'hFFFF.
REQ-018 Without GOWIN_RX_SKID_STATS_EN, stat_tlp_cnt and stat_wait_cnt SHALL be tied to 0 and no counter logic SHALL be synthesized; the ports SHALL exist in both cases.

Verification
REQ-019 The bench SHALL cover the pass-through case: single beat sop=eop=1, valid=8'hFF, data=256'hA5.., bardec=6'h01, rx_ready=1 -> rx_out_valid high for exactly 1 cycle, next cycle after push, with identical fields.
REQ-020 The bench SHALL cover the wait threshold: rx_ready=0, 5 consecutive beats (defaults) -> tl_rx_wait=1 after the edge where count reaches 5; 2 further beats accepted; count=7 with no loss.
REQ-021 The bench SHALL cover full-plus-pop: count=8, one beat pushed while rx_ready=1 -> count stays 8, head advances, rx_ovf=0.
REQ-022 The bench SHALL cover overflow: count=8, rx_ready=0, one beat pushed -> rx_ovf=1, count=8, stored data unchanged; rx_ovf stays 1 until rst_n low.
REQ-023 The bench SHALL cover pointer wrap: 20 beats with incrementing data and rx_ready toggling 1/0 -> output order matches input order exactly.
REQ-024 The bench SHALL cover the stats build: with GOWIN_RX_SKID_STATS_EN, 3 TLPs of 2 beats each -> stat_tlp_cnt=3; without the macro -> stat_tlp_cnt=0.
